// File: rtl/prog_store_pkg.sv
// rtl/prog_store_pkg.sv - shared types and constants for the program store
package prog_store_pkg;

  // Thumb instruction halfword width.
  localparam int INSTR_W = 16;

  // Load-session controller states.
  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    ERROR
  } load_state_e;

endpackage

// File: rtl/prog_store_instr_ram.sv
// rtl/prog_store_instr_ram.sv - simple dual-port instruction RAM, 1W/1R, read-before-write
module instr_ram #(
  parameter int DEPTH   = 256,
  parameter int INSTR_W = 16,
  parameter int INDEX_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               we,
  input  logic [INDEX_W-1:0] waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [INDEX_W-1:0] raddr,
  output logic [INSTR_W-1:0] rdata
);

  // DEPTH need not be a power of two, so out-of-range read indices are decoded explicitly.
  localparam logic [INDEX_W:0] DEPTH_L = (INDEX_W+1)'(DEPTH);

  logic [INSTR_W-1:0] mem [DEPTH];

  // Storage array: contents are deliberately not reset so a program survives reset_n.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read port; sees the pre-write value on a same-index collision.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata <= '0;
    end else if ({1'b0, raddr} < DEPTH_L) begin
      rdata <= mem[raddr];
    end else begin
      rdata <= '0;
    end
  end

endmodule

// File: rtl/prog_store.sv
// rtl/prog_store.sv - instruction store and load-session controller (option: PROG_CHECKSUM_EN)
module prog_store
  import prog_store_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int INDEX_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load_start,
  input  logic               load_valid,
  output logic               load_ready,
  input  logic [INDEX_W-1:0] load_index,
  input  logic [INSTR_W-1:0] load_data,
  input  logic               load_last,
`ifdef PROG_CHECKSUM_EN
  input  logic [INSTR_W-1:0] load_checksum,
`endif
  input  logic [INDEX_W-1:0] fetch_index,
  output logic [INSTR_W-1:0] fetch_instr,
  output logic               cpu_reset,
  output logic               loading,
  output logic               load_error,
  output logic [INDEX_W:0]   word_count
);

  localparam logic [INDEX_W:0] DEPTH_L = (INDEX_W+1)'(DEPTH);

  load_state_e state;
  logic        accept;
  logic        in_range;
  logic        ram_we;
  logic        last_ok;

  // load_ready is high exactly while in LOAD, so it doubles as the state qualifier here.
  assign accept   = load_valid & load_ready;
  assign in_range = ({1'b0, load_index} < DEPTH_L);
  assign ram_we   = accept & in_range;

`ifdef PROG_CHECKSUM_EN
  logic [INSTR_W-1:0] sum;
  logic [INSTR_W-1:0] sum_next;

  assign sum_next = sum + load_data;
  assign last_ok  = (sum_next == load_checksum);

  // Running modulo sum of accepted in-range halfwords, restarted on each new session.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sum <= '0;
    end else if (state != LOAD && load_start) begin
      sum <= '0;
    end else if (ram_we) begin
      sum <= sum_next;
    end
  end
`else
  assign last_ok = 1'b1;
`endif

  // Session FSM with registered per-state outputs and the accepted-beat counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cpu_reset  <= 1'b1;
      load_ready <= 1'b0;
      loading    <= 1'b0;
      load_error <= 1'b0;
      word_count <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (accept) begin
            if (!in_range) begin
              // Range violation beats load_last: the beat is dropped and the session fails.
              state      <= ERROR;
              load_ready <= 1'b0;
              loading    <= 1'b0;
              load_error <= 1'b1;
            end else begin
              if (word_count != '1) begin
                word_count <= word_count + 1'b1;
              end
              if (load_last) begin
                load_ready <= 1'b0;
                loading    <= 1'b0;
                if (last_ok) begin
                  state     <= RUN;
                  cpu_reset <= 1'b0;
                end else begin
                  state      <= ERROR;
                  load_error <= 1'b1;
                end
              end
            end
          end
        end
        default: begin
          // IDLE, RUN and ERROR all leave only through a new session.
          if (load_start) begin
            state      <= LOAD;
            cpu_reset  <= 1'b1;
            load_ready <= 1'b1;
            loading    <= 1'b1;
            load_error <= 1'b0;
            word_count <= '0;
          end
        end
      endcase
    end
  end

  instr_ram #(
    .DEPTH   (DEPTH),
    .INSTR_W (INSTR_W),
    .INDEX_W (INDEX_W)
  ) u_ram (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (ram_we),
    .waddr   (load_index),
    .wdata   (load_data),
    .raddr   (fetch_index),
    .rdata   (fetch_instr)
  );

endmodule

// File: doc/prog_store.md
Name: prog_store

Overview:
- Instruction store and load-session controller on the receiving end of the program-download interface.
- A program loader streams (index, halfword) beats into on-chip instruction RAM.
- Holds the CPU in reset until a complete, valid program has landed, then releases it.
- Serves the CPU's instruction fetch port with synchronous reads.

Parameters:
- DEPTH, 256, number of 16-bit instruction slots; need not be a power of two.
- INDEX_W, $clog2(DEPTH), width of load and fetch index buses.
- INSTR_W, 16, Thumb instruction width.

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- load_start  in  1  single-cycle pulse; opens a load session.
- load_valid  in  1  loader presents a beat.
- load_ready  out  1  store accepts a beat; a beat transfers on valid&ready.
- load_index  in  INDEX_W  target slot of the beat.
- load_data  in  INSTR_W  instruction halfword.
- load_last  in  1  marks the final beat of the session.
- fetch_index  in  INDEX_W  CPU fetch address (halfword index).
- fetch_instr  out  INSTR_W  fetched instruction, 1-cycle latency.
- cpu_reset  out  1  active-high reset to the CPU.
- loading  out  1  high in LOAD; drives the download LED.
- load_error  out  1  high in ERROR.
- word_count  out  INDEX_W+1  beats accepted in the current or last session.

Behaviour:
- Reset values: state IDLE, cpu_reset=1, load_ready=0, loading=0, load_error=0, word_count=0, fetch_instr=0.
- RAM contents are not reset; they persist across reset_n.
- Outputs by state:
  - IDLE: cpu_reset=1, ready=0. load_start -> LOAD.
  - LOAD: cpu_reset=1, ready=1, loading=1. load_start is ignored.
  - RUN: cpu_reset=0, ready=0. load_start -> LOAD.
  - ERROR: cpu_reset=1, ready=0, load_error=1. load_start -> LOAD; only load_start or reset_n exits ERROR.
- Accepted beat with load_index < DEPTH: write RAM[load_index]=load_data and increment word_count.
- Accepted beat with load_index >= DEPTH: beat is consumed but not written, word_count unchanged, next state ERROR. This takes priority over load_last.
- Accepted in-range beat with load_last=1: next state RUN. cpu_reset falls in the cycle after the accepting edge.
- Entering LOAD clears word_count to 0.
- Beats with valid=1 outside LOAD are not accepted; they have no effect.
- word_count saturates at 2^(INDEX_W+1)-1. Duplicate indices are allowed: last write wins, and each beat counts.
- Fetch:
  - fetch_instr <= RAM[fetch_index] every cycle, in every state.
  - fetch_index >= DEPTH yields 0.
  - Same-cycle write and read to one index returns the old data (read-before-write).
- reset_n asserted mid-session: immediate return to reset values. A partially written RAM keeps its written slots.

Optional Feature:
- Macro: PROG_CHECKSUM_EN.
- Defined:
  - Adds input load_checksum, INSTR_W wide, sampled on the last beat.
  - Keeps a running sum mod 2^INSTR_W of accepted in-range load_data; the sum clears on entering LOAD.
  - On the last beat, (sum + load_data) != load_checksum -> ERROR instead of RUN. The last beat is still written.
- Undefined: port absent; last beat always -> RUN (subject to the range check).

Decomposition:
- Package prog_store_pkg: enum load_state_e {IDLE, LOAD, RUN, ERROR}, constant INSTR_W=16.
- Sub-module instr_ram: simple dual-port, 1 write / 1 synchronous read, read-before-write, parameterised by DEPTH and INSTR_W.

Test Plan:
- Load session: reset, load_start, 13 beats at idx 10..22 with data 16'h2021..16'hfee7, load_last on idx 22.
  - cpu_reset falls one cycle after that beat; word_count=13.
  - fetch_index=10 -> fetch_instr=16'h2021 next cycle; idx 22 -> 16'hfee7.
- Gating: load_valid=1 with idx 5 and data 16'hAAAA while in IDLE.
  - load_ready=0; RAM[5] unchanged after a later session; word_count stays 0.
  - With load_valid toggling in LOAD, only handshaken beats count.
- Range error (DEPTH=200): beat at idx 200.
  - load_error=1, cpu_reset=1, word_count unchanged.
  - A subsequent load_start clears load_error and restarts at count 0.
- Reload and collision: in RUN, pulse load_start -> cpu_reset=1 next cycle, word_count=0.
  - Write idx 3=16'h1234 while fetch_index=3 (old 16'h0001): fetch returns 16'h0001, then 16'h1234.
- Checksum (PROG_CHECKSUM_EN): data 1,2,3.
  - load_checksum=6 -> RUN.
  - load_checksum=7 -> ERROR with RAM still holding 1,2,3.
- Reset mid-load: assert reset_n low between edges after 4 beats.
  - Outputs hit reset values without waiting for a clock edge.
  - Those 4 slots remain readable after release.
